// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential-PC fetch front end with a req/ack instruction-memory port
// and a DEPTH-entry {pc, instr} FIFO; define FETCH_PERF_EN to enable the stall_count counter.
module instr_fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
) (
    input  logic               CLK,
    input  logic               resetl,
    input  logic [ADDR_W-1:0]  startpc,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_data,
    output logic               inst_valid,
    output logic [INSTR_W-1:0] inst_data,
    output logic [ADDR_W-1:0]  inst_pc,
    input  logic               inst_ready,
    output logic [31:0]        stall_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] WORD       = ADDR_W'(4);

    typedef enum logic [1:0] {BOOT, ISSUE, REQ, DISCARD} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  pc_mem   [DEPTH];
    logic [INSTR_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count, count_after;
    logic               redir, push, pop, issue, stay_req;

    // Redirects are meaningless before the boot PC has been loaded.
    assign redir       = redirect && (state != BOOT);
    assign push        = (state == REQ) && mem_ack && !redir;
    assign pop         = inst_valid && inst_ready;
    assign count_after = count + CNT_W'(push) - CNT_W'(pop);
    assign issue       = (state == ISSUE) && !redir && (count < DEPTH_C);
    assign stay_req    = push && (count_after < DEPTH_C);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) state <= BOOT;
        else         state <= state_nxt;
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = ISSUE;
            ISSUE:   if (issue) state_nxt = REQ;
            REQ: begin
                if (redir)                     state_nxt = mem_ack ? ISSUE : DISCARD;
                else if (mem_ack && !stay_req) state_nxt = ISSUE;
            end
            DISCARD: if (mem_ack) state_nxt = ISSUE;
            default: state_nxt = BOOT;
        endcase
    end

    always_comb begin
        mem_req = (state == REQ) || (state == DISCARD);
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            fetch_pc <= '0;
            mem_addr <= '0;
        end else begin
            if (state == BOOT)  fetch_pc <= startpc & ALIGN_MASK;
            else if (redir)     fetch_pc <= redirect_pc & ALIGN_MASK;
            else if (push)      fetch_pc <= fetch_pc + WORD;

            // In DISCARD the old address is held until the stale response returns.
            if (issue)          mem_addr <= fetch_pc;
            else if (stay_req)  mem_addr <= fetch_pc + WORD;
        end
    end

    // NOTE: the small storage array is reset so the head outputs read zero out of reset.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
        end else if (redir) begin
            // A same-cycle pop has already been taken by the consumer; the rest is dropped.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]   <= mem_addr;
                data_mem[wr_ptr] <= mem_data;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_after;
        end
    end

    assign inst_valid = (count != '0);
    assign inst_data  = data_mem[rd_ptr];
    assign inst_pc    = pc_mem[rd_ptr];

`ifdef FETCH_PERF_EN
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl)
            stall_count <= '0;
        else if (inst_ready && !inst_valid && (stall_count != 32'hFFFF_FFFF))
            stall_count <= stall_count + 32'd1;
    end
`else
    assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue: table-driven streaming/backpressure
// vectors followed by hand-written redirect, reset and stall-counter sequences.
module tb_instr_fetch_queue;
    logic        CLK = 1'b0;
    logic        resetl;
    logic [63:0] startpc;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        inst_ready;
    logic [31:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_queue #(.DEPTH(4), .ADDR_W(64), .INSTR_W(32)) dut (
        .CLK(CLK), .resetl(resetl), .startpc(startpc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .stall_count(stall_count)
    );

    always #5 CLK = ~CLK;

    // Instruction memory contents: each word is a fixed function of its address.
    function automatic logic [31:0] imem(input logic [63:0] a);
        return a[31:0] ^ 32'hCAFE_0000;
    endfunction

    assign mem_data = imem(mem_addr);

    typedef struct packed {
        logic        ready;
        logic        ack;
        logic        exp_req;
        logic [63:0] exp_addr;
        logic        exp_valid;
        logic [63:0] exp_pc;
    } vec_t;

    vec_t vecs [16];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic exp_req, input logic [63:0] exp_addr,
                               input logic exp_valid, input logic [63:0] exp_pc);
        check({tag, " mem_req"}, 64'(mem_req), 64'(exp_req));
        if (exp_req) check({tag, " mem_addr"}, mem_addr, exp_addr);
        check({tag, " inst_valid"}, 64'(inst_valid), 64'(exp_valid));
        if (exp_valid) begin
            check({tag, " inst_pc"}, inst_pc, exp_pc);
            check({tag, " inst_data"}, 64'(inst_data), 64'(imem(exp_pc)));
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " mem_req"}, 64'(mem_req), 64'd0);
        check({tag, " mem_addr"}, mem_addr, 64'd0);
        check({tag, " inst_valid"}, 64'(inst_valid), 64'd0);
        check({tag, " inst_data"}, 64'(inst_data), 64'd0);
        check({tag, " inst_pc"}, inst_pc, 64'd0);
        check({tag, " stall_count"}, 64'(stall_count), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ready, ack -> req, addr, valid, pc (state after the edge)
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 64'h0,   1'b0, 64'h0  };  // BOOT -> ISSUE
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 64'h100, 1'b0, 64'h0  };  // first request
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 64'h104, 1'b1, 64'h100};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 64'h108, 1'b1, 64'h104};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 64'h10C, 1'b1, 64'h108};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 64'h10C, 1'b0, 64'h0  };  // drained, request held
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 64'h110, 1'b1, 64'h10C};  // backpressure: fill
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 64'h114, 1'b1, 64'h10C};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 64'h118, 1'b1, 64'h10C};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 64'h0,   1'b1, 64'h10C};  // 4th ack: full, stop
        vecs[10] = '{1'b0, 1'b0, 1'b0, 64'h0,   1'b1, 64'h10C};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 64'h0,   1'b1, 64'h110};  // pop frees a slot
        vecs[12] = '{1'b0, 1'b0, 1'b1, 64'h11C, 1'b1, 64'h110};  // resume at next PC
        vecs[13] = '{1'b1, 1'b1, 1'b1, 64'h120, 1'b1, 64'h114};  // push+pop at count 3
        vecs[14] = '{1'b1, 1'b1, 1'b1, 64'h124, 1'b1, 64'h118};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 64'h124, 1'b1, 64'h11C};

        resetl      = 1'b0;
        startpc     = 64'h100;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        mem_ack     = 1'b0;
        inst_ready  = 1'b0;
        repeat (2) tick();
        check_reset("reset");
        resetl = 1'b1;

        for (int i = 0; i < 16; i++) begin
            inst_ready = vecs[i].ready;
            mem_ack    = vecs[i].ack;
            tick();
            check_state($sformatf("v%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                        vecs[i].exp_valid, vecs[i].exp_pc);
        end

        // Redirect to an unaligned target while a request is outstanding.
        inst_ready  = 1'b0;
        mem_ack     = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 64'h203;
        tick();
        check_state("redir discard", 1'b1, 64'h124, 1'b0, 64'h0);
        redirect = 1'b0;
        repeat (2) begin
            tick();
            check_state("discard hold", 1'b1, 64'h124, 1'b0, 64'h0);
        end
        mem_ack = 1'b1;                     // stale response
        tick();
        check_state("stale dropped", 1'b0, 64'h0, 1'b0, 64'h0);
        mem_ack = 1'b0;
        tick();
        check_state("refetch target", 1'b1, 64'h200, 1'b0, 64'h0);
        mem_ack = 1'b1;
        tick();
        check_state("target delivered", 1'b1, 64'h204, 1'b1, 64'h200);

        // Redirect, ack and pop in the same cycle.
        redirect    = 1'b1;
        redirect_pc = 64'h400;
        mem_ack     = 1'b1;
        inst_ready  = 1'b1;
        tick();
        check_state("redir+ack+pop", 1'b0, 64'h0, 1'b0, 64'h0);
        redirect = 1'b0;
        mem_ack  = 1'b0;
        tick();
        check_state("refetch 0x400", 1'b1, 64'h400, 1'b0, 64'h0);
        mem_ack    = 1'b1;
        inst_ready = 1'b0;
        tick();
        check_state("0x400 delivered", 1'b1, 64'h404, 1'b1, 64'h400);

        // Reset asserted mid-request with an ack arriving during reset.
        mem_ack = 1'b0;
        tick();
        #3;
        resetl  = 1'b0;
        startpc = 64'h300;
        #1;
        check_reset("async reset");
        mem_ack = 1'b1;
        repeat (2) tick();
        check_reset("reset with ack");
        resetl = 1'b1;
        tick();
        check_state("boot ack ignored", 1'b0, 64'h0, 1'b0, 64'h0);
        mem_ack = 1'b0;
        tick();
        check_state("restart startpc", 1'b1, 64'h300, 1'b0, 64'h0);
        mem_ack = 1'b1;
        tick();
        check_state("restart delivered", 1'b1, 64'h304, 1'b1, 64'h300);

        // Stall counter: five ready-but-empty cycles after a fresh reset.
        mem_ack    = 1'b0;
        inst_ready = 1'b1;
        resetl     = 1'b0;
        tick();
        check("stall in reset", 64'(stall_count), 64'd0);
        resetl = 1'b1;
        repeat (5) tick();
        check("stall empty", 64'(inst_valid), 64'd0);
`ifdef FETCH_PERF_EN
        check("stall_count 5", 64'(stall_count), 64'd5);
`else
        check("stall_count off", 64'(stall_count), 64'd0);
`endif
        inst_ready = 1'b0;
        mem_ack    = 1'b1;
        tick();
        inst_ready = 1'b1;
        mem_ack    = 1'b0;
        tick();
`ifdef FETCH_PERF_EN
        check("stall_count hold", 64'(stall_count), 64'd5);
`else
        check("stall_count hold off", 64'(stall_count), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
